fx_mac_seq: RTL and testbench

- Producer-side sequencer for the fixed-point MAC.
- Accepts weight/data pairs over a valid/ready stream and buffers one dot-product vector of up to K pairs.
- Replays the buffered pairs to the MAC one per cycle, with an accumulator-clear pulse on the first pair.
- Waits out the MAC pipeline latency, captures the rounded/clipped result and offers it on a valid/ready result port.

---
 rtl/fx_mac_seq_if.sv | 24 ++
 rtl/fx_mac_seq.sv | 149 ++++++++++++++
 tb/tb_fx_mac_seq.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fx_mac_seq_if.sv
// Handshake bundle for fx_mac_seq: the input pair stream and the result port.
// Signal suffixes give the direction as seen by the sequencer.
interface fx_mac_seq_if #(
  parameter int WIDTH = 8
);
  logic                    s_vld_i;
  logic                    s_rdy_o;
  logic signed [WIDTH-1:0] s_w_i;
  logic signed [WIDTH-1:0] s_d_i;
  logic                    s_last_i;
  logic signed [WIDTH-1:0] res_o;
  logic                    res_vld_o;
  logic                    res_rdy_i;

  modport master (
    output s_vld_i, s_w_i, s_d_i, s_last_i, res_rdy_i,
    input  s_rdy_o, res_o, res_vld_o
  );

  modport slave (
    input  s_vld_i, s_w_i, s_d_i, s_last_i, res_rdy_i,
    output s_rdy_o, res_o, res_vld_o
  );
endinterface

// File: rtl/fx_mac_seq.sv
// Producer-side sequencer for the fixed-point MAC: buffers one vector of up to K
// weight/data pairs, replays it over exactly K cycles, then returns the MAC result.
module fx_mac_seq #(
  parameter int WIDTH   = 8,
  parameter int K       = 8,
  parameter int WK      = $clog2(K),
  parameter int MAC_LAT = 3
) (
  input  logic                    clk,
  input  logic                    rstn,
  fx_mac_seq_if.slave             s,
  output logic signed [WIDTH-1:0] mac_w_o,
  output logic signed [WIDTH-1:0] mac_d_o,
  output logic                    mac_clr_o,
  input  logic signed [WIDTH-1:0] mac_acc_i,
  output logic                    len_err_o
);

  localparam int WL = $clog2(MAC_LAT) + 1;

  typedef enum logic [1:0] {LOAD, ISSUE, WAIT, OUT} state_t;

  state_t                  state_q, state_d;
  logic [WK-1:0]           cnt_q, cnt_d;
  logic [WK:0]             len_q, len_d;
  logic [WL-1:0]           wcnt_q, wcnt_d;
  logic signed [WIDTH-1:0] mac_w_q, mac_w_d;
  logic signed [WIDTH-1:0] mac_d_q, mac_d_d;
  logic                    mac_clr_q, mac_clr_d;
  logic signed [WIDTH-1:0] res_q, res_d;
  logic                    res_vld_q, res_vld_d;
  logic                    s_rdy_q, s_rdy_d;

  logic [2*WIDTH-1:0]      mem_q [K];

  logic                    accept;
  logic                    at_full;
  logic                    term;
  logic [WK:0]             nxt_idx;

  always_comb begin
    accept    = s.s_vld_i & s_rdy_q;
    at_full   = (cnt_q == WK'(K - 1));
    term      = accept & (s.s_last_i | at_full);
    len_err_o = accept & at_full & ~s.s_last_i;
    nxt_idx   = {1'b0, cnt_q} + (WK+1)'(1);

    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    wcnt_d    = wcnt_q;
    mac_w_d   = '0;
    mac_d_d   = '0;
    mac_clr_d = 1'b0;
    res_d     = res_q;

    unique case (state_q)
      LOAD: begin
        if (accept) begin
          if (term) begin
            // Pair 0 is staged now so it is on the MAC bus in the first ISSUE cycle;
            // a 1-pair vector has to bypass the buffer write happening this cycle.
            state_d   = ISSUE;
            cnt_d     = '0;
            len_d     = nxt_idx;
            mac_clr_d = 1'b1;
            if (cnt_q == '0) begin
              mac_w_d = s.s_w_i;
              mac_d_d = s.s_d_i;
            end else begin
              {mac_w_d, mac_d_d} = mem_q[0];
            end
          end else begin
            cnt_d = cnt_q + WK'(1);
          end
        end
      end
      ISSUE: begin
        // cnt_q is the pair currently on the bus; stage the next one or zero padding.
        cnt_d = cnt_q + WK'(1);
        if (nxt_idx < len_q) begin
          {mac_w_d, mac_d_d} = mem_q[nxt_idx[WK-1:0]];
        end
        if (at_full) begin
          cnt_d   = '0;
          wcnt_d  = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        wcnt_d = wcnt_q + WL'(1);
        if (wcnt_q == WL'(MAC_LAT - 1)) begin
          res_d   = mac_acc_i;
          state_d = OUT;
        end
      end
      OUT: begin
        if (s.res_rdy_i) begin
          state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase

    s_rdy_d   = (state_d == LOAD);
    res_vld_d = (state_d == OUT);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= LOAD;
      cnt_q     <= '0;
      len_q     <= '0;
      wcnt_q    <= '0;
      mac_w_q   <= '0;
      mac_d_q   <= '0;
      mac_clr_q <= 1'b0;
      res_q     <= '0;
      res_vld_q <= 1'b0;
      s_rdy_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      wcnt_q    <= wcnt_d;
      mac_w_q   <= mac_w_d;
      mac_d_q   <= mac_d_d;
      mac_clr_q <= mac_clr_d;
      res_q     <= res_d;
      res_vld_q <= res_vld_d;
      s_rdy_q   <= s_rdy_d;
    end
  end

  // Pair buffer has no reset: its contents are only read after being written.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[cnt_q] <= {s.s_w_i, s.s_d_i};
    end
  end

  assign s.s_rdy_o   = s_rdy_q;
  assign s.res_o     = res_q;
  assign s.res_vld_o = res_vld_q;
  assign mac_w_o     = mac_w_q;
  assign mac_d_o     = mac_d_q;
  assign mac_clr_o   = mac_clr_q;

endmodule

// File: tb/tb_fx_mac_seq.sv
// Bench for fx_mac_seq with an ideal 3-stage Q4.4 MAC; expected results are
// queued when a vector is driven and popped when the result handshake occurs.
module tb_fx_mac_seq;
  localparam int W = 8;
  localparam int K = 8;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  fx_mac_seq_if #(.WIDTH(W)) ifc ();

  logic signed [W-1:0] mac_w, mac_d, mac_acc;
  logic                mac_clr, len_err;

  fx_mac_seq #(.WIDTH(W), .K(K), .MAC_LAT(3)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .s         (ifc),
    .mac_w_o   (mac_w),
    .mac_d_o   (mac_d),
    .mac_clr_o (mac_clr),
    .mac_acc_i (mac_acc),
    .len_err_o (len_err)
  );

  function automatic int sat_round(input int a);
    int r;
    r = (a + 8) >>> 4;
    if (r > 127) r = 127;
    else if (r < -128) r = -128;
    return r;
  endfunction

  // Ideal MAC: multiply reg, accumulate reg, round/clip reg.
  int                  m_p = 0;
  int                  m_acc = 0;
  logic                m_clr = 1'b0;
  logic signed [W-1:0] m_out = '0;
  always @(posedge clk) begin
    m_p   <= int'(mac_w) * int'(mac_d);
    m_clr <= mac_clr;
    m_acc <= m_clr ? m_p : m_acc + m_p;
    m_out <= 8'(sat_round(m_acc));
  end
  assign mac_acc = m_out;

  int                  cyc = 0;
  int                  clr_cnt = 0;
  int                  lerr_cnt = 0;
  int                  icnt = K;
  logic signed [W-1:0] iss_w [K];
  logic signed [W-1:0] iss_d [K];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (len_err) lerr_cnt <= lerr_cnt + 1;
  end
  always @(negedge clk) begin
    if (mac_clr) begin
      clr_cnt  <= clr_cnt + 1;
      iss_w[0] <= mac_w;
      iss_d[0] <= mac_d;
      icnt     <= 1;
    end else if (icnt < K) begin
      iss_w[icnt] <= mac_w;
      iss_d[icnt] <= mac_d;
      icnt        <= icnt + 1;
    end
  end

  int                  checks = 0;
  int                  failures = 0;
  logic [W-1:0]        exp_q [$];
  logic signed [W-1:0] vw [K];
  logic signed [W-1:0] vd [K];

  task automatic send_beat(input logic signed [W-1:0] w, input logic signed [W-1:0] d,
                           input logic last, output int acc_cyc, output logic le, output bit to);
    int n;
    n = 0;
    ifc.s_vld_i = 1'b1; ifc.s_w_i = w; ifc.s_d_i = d; ifc.s_last_i = last;
    #1;
    while (!ifc.s_rdy_o && n < 100) begin @(negedge clk); #1; n++; end
    to = !ifc.s_rdy_o;
    acc_cyc = cyc;
    le = len_err;
    @(negedge clk);
    ifc.s_vld_i = 1'b0; ifc.s_last_i = 1'b0;
  endtask

  task automatic send_vec(input int len, input bit use_last, input int max_gap,
                          output int last_cyc, output int lerr_beats, output bit to);
    logic le;
    bit   t;
    int   ac;
    lerr_beats = 0; to = 0; last_cyc = 0;
    for (int i = 0; i < len; i++) begin
      send_beat(vw[i], vd[i], use_last && (i == len - 1), ac, le, t);
      if (t) to = 1;
      if (le) lerr_beats++;
      last_cyc = ac;
      if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) @(negedge clk);
    end
  endtask

  task automatic wait_vld(output bit to);
    int n;
    n = 0;
    while (!ifc.res_vld_o && n < 100) begin @(negedge clk); n++; end
    to = !ifc.res_vld_o;
  endtask

  task automatic take_result(input int dly, output logic [W-1:0] r);
    repeat (dly) @(negedge clk);
    r = ifc.res_o;
    ifc.res_rdy_i = 1'b1;
    @(negedge clk);
    ifc.res_rdy_i = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ifc.s_rdy_o, ifc.res_vld_o, mac_clr, len_err, mac_w, mac_d, ifc.res_o} !== '0) begin
      $display("FAIL reset_outputs: got rdy=%b vld=%b clr=%b lerr=%b w=%h d=%h res=%h want all 0",
               ifc.s_rdy_o, ifc.res_vld_o, mac_clr, len_err, mac_w, mac_d, ifc.res_o);
      failures++;
    end
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (ifc.s_rdy_o !== 1'b1) begin
      $display("FAIL reset_rdy_after: got %b want 1", ifc.s_rdy_o); failures++;
    end
    $display("test_reset done");
  endtask

  task automatic test_full_vector();
    int lc, lb, c0, l0, vc;
    bit to, to2;
    logic [W-1:0] r, e;
    for (int i = 0; i < K; i++) begin vw[i] = 8'sh10; vd[i] = 8'sh10; end
    c0 = clr_cnt; l0 = lerr_cnt;
    exp_q.push_back(8'h7F);
    send_vec(8, 1, 0, lc, lb, to);
    wait_vld(to2);
    vc = cyc;
    take_result(0, r);
    e = exp_q.pop_front();
    checks++;
    if (to || to2) begin $display("FAIL full_timeout: got timeout want none"); failures++; end
    checks++;
    if (vc - lc !== 12) begin $display("FAIL full_latency: got %0d want 12", vc - lc); failures++; end
    checks++;
    if (r !== e) begin $display("FAIL full_res: got %h want %h", r, e); failures++; end
    checks++;
    if (lerr_cnt - l0 !== 0) begin $display("FAIL full_len_err: got %0d want 0", lerr_cnt - l0); failures++; end
    checks++;
    if (clr_cnt - c0 !== 1) begin $display("FAIL full_clr: got %0d want 1", clr_cnt - c0); failures++; end
    $display("test_full_vector res=%h latency=%0d", r, vc - lc);
  endtask

  task automatic test_short_vector();
    int lc, lb, c0;
    bit to, to2;
    logic [W-1:0] r, e, ev;
    for (int i = 0; i < K; i++) begin vw[i] = 8'sh10; vd[i] = 8'sh10; end
    c0 = clr_cnt;
    exp_q.push_back(8'h40);
    send_vec(4, 1, 0, lc, lb, to);
    wait_vld(to2);
    take_result(1, r);
    e = exp_q.pop_front();
    checks++;
    if (to || to2) begin $display("FAIL short_timeout: got timeout want none"); failures++; end
    checks++;
    if (r !== e) begin $display("FAIL short_res: got %h want %h", r, e); failures++; end
    checks++;
    if (clr_cnt - c0 !== 1) begin $display("FAIL short_clr: got %0d want 1", clr_cnt - c0); failures++; end
    for (int i = 0; i < K; i++) begin
      ev = (i < 4) ? 8'h10 : 8'h00;
      checks++;
      if ({iss_w[i], iss_d[i]} !== {ev, ev}) begin
        $display("FAIL short_issue[%0d]: got w=%h d=%h want w=%h d=%h", i, iss_w[i], iss_d[i], ev, ev);
        failures++;
      end
    end
    $display("test_short_vector res=%h", r);
  endtask

  task automatic test_len_err();
    int lc, lb, l0;
    bit to, to2;
    logic [W-1:0] r, e;
    for (int i = 0; i < K; i++) begin vw[i] = 8'sh20; vd[i] = -8'sh10; end
    l0 = lerr_cnt;
    exp_q.push_back(8'h80);
    send_vec(8, 0, 0, lc, lb, to);
    wait_vld(to2);
    take_result(0, r);
    e = exp_q.pop_front();
    checks++;
    if (to || to2) begin $display("FAIL lerr_timeout: got timeout want none"); failures++; end
    checks++;
    if (lb !== 1) begin $display("FAIL lerr_on_beat8: got %0d beats want 1", lb); failures++; end
    checks++;
    if (lerr_cnt - l0 !== 1) begin $display("FAIL lerr_pulses: got %0d want 1", lerr_cnt - l0); failures++; end
    checks++;
    if (r !== e) begin $display("FAIL lerr_res: got %h want %h", r, e); failures++; end
    $display("test_len_err res=%h pulses=%0d", r, lerr_cnt - l0);
  endtask

  task automatic test_back_to_back();
    int lc, lb, bad_res, bad_vld, bad_rdy;
    bit to, to2;
    logic le;
    logic [W-1:0] r0, r, e;
    vw[0] = 8'sh10; vd[0] = 8'sh10; vw[1] = 8'sh10; vd[1] = 8'sh10;
    exp_q.push_back(8'h20);
    send_vec(2, 1, 0, lc, lb, to);
    wait_vld(to2);
    r0 = ifc.res_o;
    ifc.s_vld_i = 1'b1; ifc.s_w_i = 8'sh08; ifc.s_d_i = 8'sh10; ifc.s_last_i = 1'b1;
    bad_res = 0; bad_vld = 0; bad_rdy = 0;
    repeat (20) begin
      @(negedge clk);
      if (ifc.res_o !== r0) bad_res++;
      if (ifc.res_vld_o !== 1'b1) bad_vld++;
      if (ifc.s_rdy_o !== 1'b0) bad_rdy++;
    end
    e = exp_q.pop_front();
    checks++;
    if (to || to2) begin $display("FAIL bp_timeout: got timeout want none"); failures++; end
    checks++;
    if (r0 !== e) begin $display("FAIL bp_res: got %h want %h", r0, e); failures++; end
    checks++;
    if (bad_res !== 0) begin $display("FAIL bp_res_stable: got %0d changes want 0", bad_res); failures++; end
    checks++;
    if (bad_vld !== 0) begin $display("FAIL bp_vld_held: got %0d drops want 0", bad_vld); failures++; end
    checks++;
    if (bad_rdy !== 0) begin $display("FAIL bp_rdy_low: got %0d high cycles want 0", bad_rdy); failures++; end
    ifc.res_rdy_i = 1'b1;
    @(negedge clk);
    ifc.res_rdy_i = 1'b0;
    checks++;
    if ({ifc.s_rdy_o, ifc.res_vld_o} !== 2'b10) begin
      $display("FAIL bp_after_hs: got rdy=%b vld=%b want rdy=1 vld=0", ifc.s_rdy_o, ifc.res_vld_o);
      failures++;
    end
    exp_q.push_back(8'h08);
    send_beat(8'sh08, 8'sh10, 1'b1, lc, le, to);
    wait_vld(to2);
    take_result(0, r);
    e = exp_q.pop_front();
    checks++;
    if (r !== e || to || to2) begin $display("FAIL bp_next_res: got %h want %h", r, e); failures++; end
    $display("test_back_to_back held=%h next=%h", r0, r);
  endtask

  task automatic test_reset_mid_issue();
    int lc, lb, c0;
    bit to, to2;
    logic [W-1:0] r, e;
    for (int i = 0; i < K; i++) begin vw[i] = 8'sh10; vd[i] = 8'sh10; end
    send_vec(8, 1, 0, lc, lb, to);
    repeat (3) @(negedge clk);
    checks++;
    if (mac_w !== 8'sh10) begin $display("FAIL mid_issue_active: got %h want 10", mac_w); failures++; end
    rstn = 1'b0;
    #1;
    checks++;
    if ({ifc.s_rdy_o, ifc.res_vld_o, mac_clr, len_err, mac_w, mac_d, ifc.res_o} !== '0) begin
      $display("FAIL mid_reset_outputs: got rdy=%b vld=%b clr=%b w=%h d=%h res=%h want all 0",
               ifc.s_rdy_o, ifc.res_vld_o, mac_clr, mac_w, mac_d, ifc.res_o);
      failures++;
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    vw[0] = 8'sh18; vd[0] = 8'sh10;
    c0 = clr_cnt;
    exp_q.push_back(8'h18);
    send_vec(1, 1, 0, lc, lb, to);
    wait_vld(to2);
    take_result(0, r);
    e = exp_q.pop_front();
    checks++;
    if (r !== e || to || to2) begin $display("FAIL mid_fresh_res: got %h want %h", r, e); failures++; end
    repeat (4) @(negedge clk);
    checks++;
    if (clr_cnt - c0 !== 1) begin $display("FAIL mid_clr_once: got %0d want 1", clr_cnt - c0); failures++; end
    $display("test_reset_mid_issue res=%h", r);
  endtask

  task automatic test_random();
    int lc, lb, c0, len, sum, l0;
    bit to, to2, early;
    logic [W-1:0] r, e, ew, ed;
    for (int v = 0; v < 16; v++) begin
      len = $urandom_range(K, 1);
      sum = 0;
      for (int i = 0; i < K; i++) begin
        vw[i] = 8'(int'($urandom_range(31, 0)) - 16);
        vd[i] = 8'(int'($urandom_range(31, 0)) - 16);
        if (i < len) sum += int'(vw[i]) * int'(vd[i]);
      end
      exp_q.push_back(8'(sat_round(sum)));
      c0 = clr_cnt; l0 = lerr_cnt;
      early = 1'($urandom_range(1, 0));
      ifc.res_rdy_i = early;
      send_vec(len, 1, 2, lc, lb, to);
      wait_vld(to2);
      take_result(early ? 0 : $urandom_range(3, 0), r);
      e = exp_q.pop_front();
      checks++;
      if (r !== e || to || to2) begin
        $display("FAIL rand_res[%0d] len=%0d: got %h want %h", v, len, r, e); failures++;
      end
      checks++;
      if (clr_cnt - c0 !== 1 || lerr_cnt - l0 !== 0) begin
        $display("FAIL rand_clr_lerr[%0d]: got clr=%0d lerr=%0d want 1 0", v, clr_cnt - c0, lerr_cnt - l0);
        failures++;
      end
      for (int i = 0; i < K; i++) begin
        ew = (i < len) ? vw[i] : 8'h00;
        ed = (i < len) ? vd[i] : 8'h00;
        checks++;
        if ({iss_w[i], iss_d[i]} !== {ew, ed}) begin
          $display("FAIL rand_issue[%0d][%0d]: got w=%h d=%h want w=%h d=%h", v, i, iss_w[i], iss_d[i], ew, ed);
          failures++;
        end
      end
      $display("test_random vec=%0d len=%0d res=%h exp=%h", v, len, r, e);
    end
  endtask

  initial begin
    ifc.s_vld_i = 1'b0; ifc.s_w_i = '0; ifc.s_d_i = '0; ifc.s_last_i = 1'b0; ifc.res_rdy_i = 1'b0;
    test_reset();
    test_full_vector();
    test_short_vector();
    test_len_err();
    test_back_to_back();
    test_reset_mid_issue();
    test_random();
    checks++;
    if (exp_q.size() !== 0) begin
      $display("FAIL scoreboard_empty: got %0d left want 0", exp_q.size()); failures++;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
